// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the operand entry block: op codes, FSM states,
// and the wrap-around step helpers used for the a/b/op registers.
package operand_entry_pkg;

  localparam int DEBOUNCE_DEFAULT = 1000000;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [0:0] {
    EDIT   = 1'b0,
    COMMIT = 1'b1
  } state_e;

  // >= rather than == keeps the register self-correcting if it ever leaves range
  function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic [7:0] max_v,
                                           input logic down);
    if (down) return (v == 8'd0 || v > max_v) ? max_v : v - 8'd1;
    return (v >= max_v) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic logic [1:0] op_step(input logic [1:0] v, input logic down);
    return down ? v - 2'd1 : v + 2'd1;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchronizer, counting debouncer, and a one-cycle
// press pulse on a debounced 1->0 transition.
module key_debounce
  import operand_entry_pkg::*;
#(
  parameter int CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic key,
  output logic press,
  output logic level
);

  localparam int CW = (CYCLES < 2) ? 1 : $clog2(CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_d;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync    <= 2'b11;
      cnt     <= '0;
      level   <= 1'b1;
      level_d <= 1'b1;
    end else begin
      sync    <= {sync[0], key};
      level_d <= level;
      // any cycle agreeing with the current level restarts the count
      if (sync[1] != level) begin
        if (cnt == CW'(CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level_d & ~level;

endmodule

// File: rtl/operand_entry.sv
// Operand entry: debounced keys step a/b/op, KEY[3] commits the set and holds
// it under valid until the ready handshake. Optional OPERAND_DOWN_EN: SW[17] selects decrement.
module operand_entry
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int MAX_VALUE       = 9
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic [3:0]  KEY,
  input  logic [17:0] SW,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [1:0]  op,
  output logic        valid,
  input  logic        ready
);

  localparam logic [7:0] MAX_V = 8'(MAX_VALUE);

  logic [3:0] press;
  logic [3:0] key_level;
  logic       down;
  state_e     state;

  key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_key [3:0] (
    .gclk  (CLOCK_50),
    .grst_n(RESET_N),
    .key   (KEY),
    .press (press),
    .level (key_level)
  );

`ifdef OPERAND_DOWN_EN
  assign down = SW[17];
`else
  assign down = 1'b0;
`endif

  logic unused_sink;
  assign unused_sink = &{1'b0, SW, key_level};

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      a     <= 8'd0;
      b     <= 8'd0;
      op    <= OP_ADD;
      state <= EDIT;
    end else begin
      case (state)
        EDIT: begin
          // steps land in the same cycle as a commit, before the freeze
          if (press[2]) a  <= wrap_step(a, MAX_V, down);
          if (press[1]) b  <= wrap_step(b, MAX_V, down);
          if (press[0]) op <= op_step(op, down);
          if (press[3]) state <= COMMIT;
        end
        COMMIT: if (ready) state <= EDIT;
        default: state <= EDIT;
      endcase
    end
  end

  assign valid = (state == COMMIT);

endmodule
